// File: rtl/cam_cmd_issuer.sv
// cam_cmd_issuer: issues one command word at a time to a CAM and returns a completion record.
// Defining CAM_CMD_ISSUER_TIMEOUT_EN builds a watchdog on the wait for CAM completion.
module cam_cmd_issuer #(
    parameter int C_DATA_WIDTH   = 512,
    parameter int OP_CODE_WIDTH  = 3,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [OP_CODE_WIDTH-1:0] cmd_op,
    input  logic [C_DATA_WIDTH-33:0] cmd_payload,
    output logic [C_DATA_WIDTH-1:0]  data_out,
    output logic                     data_out_valid,
    input  logic                     search_end,
    input  logic                     update_all_end,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [OP_CODE_WIDTH-1:0] resp_op,
    output logic                     resp_err,
    output logic                     resp_timeout,
    output logic [15:0]              cmd_count
);

    localparam logic [OP_CODE_WIDTH-1:0] OP_UPDATE_ALL = OP_CODE_WIDTH'(1);
    localparam logic [OP_CODE_WIDTH-1:0] OP_SEARCH     = OP_CODE_WIDTH'(2);
    localparam logic [OP_CODE_WIDTH-1:0] OP_UPDATE_ONE = OP_CODE_WIDTH'(3);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_END = 2'd2,
        RESP     = 2'd3
    } state_t;

    state_t                   state_r;
    logic [OP_CODE_WIDTH-1:0] op_r;
    logic                     end_hit_s;
    logic                     wd_expire_s;

    function automatic logic op_is_legal(input logic [OP_CODE_WIDTH-1:0] op);
        case (op)
            OP_UPDATE_ALL, OP_SEARCH, OP_UPDATE_ONE: return 1'b1;
            default:                                 return 1'b0;
        endcase
    endfunction

    // Selects the completion strobe that belongs to the opcode in flight
    always_comb begin
        end_hit_s = 1'b0;
        if (op_r == OP_UPDATE_ALL) begin
            end_hit_s = update_all_end;
        end else begin
            end_hit_s = search_end;
        end
    end

`ifdef CAM_CMD_ISSUER_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES);

    logic [WD_W-1:0] wdog_r;

    assign wd_expire_s = (state_r == WAIT_END) && (wdog_r == WD_W'(TIMEOUT_CYCLES - 1));

    // Counts cycles spent waiting for completion; held at zero in every other state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_r <= '0;
        end else if ((state_r == WAIT_END) && !wd_expire_s) begin
            wdog_r <= wdog_r + WD_W'(1);
        end else begin
            wdog_r <= '0;
        end
    end
`else
    logic unused_timeout_s;

    assign wd_expire_s      = 1'b0;
    assign unused_timeout_s = (TIMEOUT_CYCLES != 0);
`endif

    // Request sequencing; every port-facing output is a register updated with the state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= IDLE;
            op_r           <= '0;
            cmd_ready      <= 1'b0;
            data_out       <= '0;
            data_out_valid <= 1'b0;
            resp_valid     <= 1'b0;
            resp_op        <= '0;
            resp_err       <= 1'b0;
            resp_timeout   <= 1'b0;
            cmd_count      <= 16'h0000;
        end else begin
            case (state_r)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        op_r      <= cmd_op;
                        if (op_is_legal(cmd_op)) begin
                            state_r        <= ISSUE;
                            data_out       <= {cmd_payload, 32'(cmd_op)};
                            data_out_valid <= 1'b1;
                        end else begin
                            // Illegal opcodes never reach the CAM
                            state_r      <= RESP;
                            resp_valid   <= 1'b1;
                            resp_op      <= cmd_op;
                            resp_err     <= 1'b1;
                            resp_timeout <= 1'b0;
                        end
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end
                ISSUE: begin
                    state_r        <= WAIT_END;
                    data_out       <= '0;
                    data_out_valid <= 1'b0;
                    cmd_count      <= cmd_count + 16'd1;
                end
                WAIT_END: begin
                    if (end_hit_s) begin
                        state_r      <= RESP;
                        resp_valid   <= 1'b1;
                        resp_op      <= op_r;
                        resp_err     <= 1'b0;
                        resp_timeout <= 1'b0;
                    end else if (wd_expire_s) begin
                        state_r      <= RESP;
                        resp_valid   <= 1'b1;
                        resp_op      <= op_r;
                        resp_err     <= 1'b0;
                        resp_timeout <= 1'b1;
                    end else begin
                        state_r <= WAIT_END;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state_r      <= IDLE;
                        cmd_ready    <= 1'b1;
                        resp_valid   <= 1'b0;
                        resp_op      <= '0;
                        resp_err     <= 1'b0;
                        resp_timeout <= 1'b0;
                    end else begin
                        state_r <= RESP;
                    end
                end
                default: begin
                    state_r        <= IDLE;
                    cmd_ready      <= 1'b0;
                    data_out       <= '0;
                    data_out_valid <= 1'b0;
                    resp_valid     <= 1'b0;
                    resp_op        <= '0;
                    resp_err       <= 1'b0;
                    resp_timeout   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cam_cmd_issuer.sv
// Bench for cam_cmd_issuer: random requests are turned into expected issue words and
// completion records by a transaction-level model; a separate monitor scores the DUT.
module tb_cam_cmd_issuer;

    localparam int DW  = 512;
    localparam int OPW = 3;
    localparam int TO  = 8;
    localparam int PW  = DW - 32;

    typedef struct {
        logic [DW-1:0] word;
        int            cyc;
    } issue_t;

    typedef struct {
        logic [OPW-1:0] op;
        logic           err;
        logic           tmo;
        logic [15:0]    cnt;
        int             cyc;
    } resp_t;

    logic           clk;
    logic           rst_n;
    logic           cmd_valid;
    logic           cmd_ready;
    logic [OPW-1:0] cmd_op;
    logic [PW-1:0]  cmd_payload;
    logic [DW-1:0]  data_out;
    logic           data_out_valid;
    logic           search_end;
    logic           update_all_end;
    logic           resp_valid;
    logic           resp_ready;
    logic [OPW-1:0] resp_op;
    logic           resp_err;
    logic           resp_timeout;
    logic [15:0]    cmd_count;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    bit          busy    = 1'b0;
    bit          mon_en  = 1'b0;
    bit          resp_seen = 1'b0;
    int          rr_mode = 0;
    logic [15:0] exp_count = 16'h0000;
    issue_t      issue_q[$];
    resp_t       resp_q[$];
    logic [OPW-1:0] illegal_ops [5] = '{3'd0, 3'd4, 3'd5, 3'd6, 3'd7};

    cam_cmd_issuer #(
        .C_DATA_WIDTH  (DW),
        .OP_CODE_WIDTH (OPW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_op        (cmd_op),
        .cmd_payload   (cmd_payload),
        .data_out      (data_out),
        .data_out_valid(data_out_valid),
        .search_end    (search_end),
        .update_all_end(update_all_end),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_op       (resp_op),
        .resp_err      (resp_err),
        .resp_timeout  (resp_timeout),
        .cmd_count     (cmd_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name, input string what);
        n_tests++;
        n_fail++;
        $display("FAIL %s: %s (cycle %0d)", name, what, cyc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [PW-1:0] rand_pl();
        logic [PW-1:0] p;
        for (int i = 0; i < PW / 32; i++) p[i*32 +: 32] = $urandom();
        return p;
    endfunction

    function automatic bit is_legal(input logic [OPW-1:0] op);
        return (op >= 3'd1) && (op <= 3'd3);
    endfunction

    task automatic set_ends(input bit is_all, input bit right, input bit wrong);
        if (is_all) begin
            update_all_end = right;
            search_end     = wrong;
        end else begin
            search_end     = right;
            update_all_end = wrong;
        end
    endtask

    // Presents a request until taken; k is the cycle in which the DUT reacts to it
    task automatic accept(input logic [OPW-1:0] op, input logic [PW-1:0] pl,
                          output bit ok, output int k);
        int     n;
        issue_t ie;
        resp_t  re;
        ok = 1'b0;
        k  = 0;
        n  = 0;
        cmd_op      = op;
        cmd_payload = pl;
        cmd_valid   = 1'b1;
        while (1) begin
            @(negedge clk);
            if (cmd_ready) break;
            n++;
            if (n > 400) begin
                fail("accept_wait", "request never accepted");
                cmd_valid = 1'b0;
                return;
            end
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        k    = cyc;
        busy = 1'b1;
        ok   = 1'b1;
        if (is_legal(op)) begin
            exp_count = exp_count + 16'd1;
            ie.word = (DW'(pl) << 32) | DW'(op);
            ie.cyc  = k;
            issue_q.push_back(ie);
        end else begin
            re.op  = op;
            re.err = 1'b1;
            re.tmo = 1'b0;
            re.cnt = exp_count;
            re.cyc = k;
            resp_q.push_back(re);
        end
    endtask

    // One request end to end; d = WAIT_END cycles before completion, negative = never
    task automatic do_txn(input logic [OPW-1:0] op, input logic [PW-1:0] pl, input int d,
                          input bit force_wrong, output int k);
        bit    ok;
        bit    is_all;
        resp_t re;
        accept(op, pl, ok, k);
        if (!ok || !is_legal(op)) return;
        is_all = (op == 3'd1);
        search_end     = 1'($urandom_range(0, 1));
        update_all_end = 1'($urandom_range(0, 1));
        tick();
        set_ends(is_all, 1'b0, 1'b0);
        if (d < 0) begin
`ifdef CAM_CMD_ISSUER_TIMEOUT_EN
            re.op  = op;
            re.err = 1'b0;
            re.tmo = 1'b1;
            re.cnt = exp_count;
            re.cyc = k + 1 + TO;
            resp_q.push_back(re);
            repeat (TO) begin
                set_ends(is_all, 1'b0, 1'($urandom_range(0, 1)));
                tick();
            end
            set_ends(is_all, 1'b0, 1'b0);
`else
            repeat (100) begin
                set_ends(is_all, 1'b0, 1'($urandom_range(0, 1)));
                tick();
            end
            set_ends(is_all, 1'b0, 1'b0);
            check("no_resp_without_end", DW'(resp_valid), DW'(0));
`endif
            return;
        end
        repeat (d) begin
            set_ends(is_all, 1'b0, force_wrong | 1'($urandom_range(0, 1)));
            tick();
        end
        set_ends(is_all, 1'b1, 1'($urandom_range(0, 1)));
        re.op  = op;
        re.err = 1'b0;
        re.tmo = 1'b0;
        re.cnt = exp_count;
        re.cyc = cyc + 1;
        resp_q.push_back(re);
        tick();
        set_ends(is_all, 1'b0, 1'b0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (busy || (resp_q.size() != 0)) begin
            tick();
            n++;
            if (n > 500) begin
                fail("drain", "outstanding response never delivered");
                return;
            end
        end
    endtask

    // Asynchronous reset from mid-cycle: outputs must clear at once, nothing stays pending
    task automatic apply_reset();
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        check("rst_cmd_ready", DW'(cmd_ready), DW'(0));
        check("rst_data_out", data_out, '0);
        check("rst_data_out_valid", DW'(data_out_valid), DW'(0));
        check("rst_resp_valid", DW'(resp_valid), DW'(0));
        check("rst_resp_op", DW'(resp_op), DW'(0));
        check("rst_resp_err", DW'(resp_err), DW'(0));
        check("rst_resp_timeout", DW'(resp_timeout), DW'(0));
        check("rst_cmd_count", DW'(cmd_count), DW'(0));
        issue_q.delete();
        resp_q.delete();
        busy      = 1'b0;
        resp_seen = 1'b0;
        exp_count = 16'h0000;
        cmd_valid = 1'b0;
        search_end     = 1'b0;
        update_all_end = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_low_after_reset", DW'(cmd_ready), DW'(0));
        @(negedge clk);
        check("ready_high_after_reset", DW'(cmd_ready), DW'(1));
        tick();
        mon_en = 1'b1;
    endtask

    initial begin
        resp_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rr_mode)
                1:       resp_ready = 1'b0;
                2:       resp_ready = 1'b1;
                default: resp_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: scores every issue word and completion record against the queues
    initial begin
        issue_t ie;
        resp_t  re;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (data_out_valid) begin
                    if (issue_q.size() == 0) begin
                        fail("spurious_issue", $sformatf("data_out_valid=1 data_out=%0h", data_out));
                    end else begin
                        ie = issue_q.pop_front();
                        check("issue_word", data_out, ie.word);
                        check("issue_cycle", DW'(cyc), DW'(ie.cyc));
                    end
                end else begin
                    check("data_out_zero", data_out, '0);
                end
                check("cmd_ready", DW'(cmd_ready), DW'(!busy));
                if (resp_valid) begin
                    if (resp_q.size() == 0) begin
                        fail("spurious_resp", $sformatf("resp_valid=1 op=%0d err=%0b tmo=%0b",
                             resp_op, resp_err, resp_timeout));
                    end else begin
                        re = resp_q[0];
                        if (!resp_seen) check("resp_cycle", DW'(cyc), DW'(re.cyc));
                        resp_seen = 1'b1;
                        check("resp_op", DW'(resp_op), DW'(re.op));
                        check("resp_err", DW'(resp_err), DW'(re.err));
                        check("resp_timeout", DW'(resp_timeout), DW'(re.tmo));
                        if (resp_ready) begin
                            check("cmd_count", DW'(cmd_count), DW'(re.cnt));
                            void'(resp_q.pop_front());
                            resp_seen = 1'b0;
                            busy      = 1'b0;
                        end
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        fail("global_timeout", "simulation did not complete");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        int             k1;
        int             k2;
        bit             ok;
        logic [PW-1:0]  pl;
        logic [OPW-1:0] op;
        rst_n          = 1'b0;
        cmd_valid      = 1'b0;
        cmd_op         = '0;
        cmd_payload    = '0;
        search_end     = 1'b0;
        update_all_end = 1'b0;
        #12;
        apply_reset();

        do_txn(3'd2, PW'(16'hABCD), 4, 1'b0, k1);
        do_txn(3'd1, rand_pl(), 3, 1'b1, k1);
        do_txn(3'd5, rand_pl(), 0, 1'b0, k1);
        drain();

        rr_mode = 2;
        do_txn(3'd2, rand_pl(), 0, 1'b0, k1);
        do_txn(3'd3, rand_pl(), 0, 1'b0, k2);
        check("min_turnaround", DW'(k2 - k1), DW'(4));
        drain();

        // Backpressure: response must hold and the waiting request must not be taken
        rr_mode = 1;
        do_txn(3'd2, rand_pl(), 1, 1'b0, k1);
        pl          = rand_pl();
        cmd_op      = 3'd3;
        cmd_payload = pl;
        cmd_valid   = 1'b1;
        repeat (10) tick();
        rr_mode = 0;
        do_txn(3'd3, pl, 2, 1'b0, k2);
        drain();

`ifdef CAM_CMD_ISSUER_TIMEOUT_EN
        do_txn(3'd2, rand_pl(), -1, 1'b0, k1);
        drain();
        do_txn(3'd1, rand_pl(), TO - 1, 1'b0, k1);
        drain();
        accept(3'd2, rand_pl(), ok, k1);
        repeat (3) tick();
        apply_reset();
`else
        do_txn(3'd2, rand_pl(), -1, 1'b0, k1);
        apply_reset();
`endif

        force dut.cmd_count = 16'hFFFF;
        #1;
        release dut.cmd_count;
        exp_count = 16'hFFFF;
        #1;
        check("count_preload", DW'(cmd_count), DW'(16'hFFFF));
        tick();
        do_txn(3'd2, rand_pl(), 0, 1'b0, k1);
        drain();
        check("count_wrapped", DW'(cmd_count), DW'(0));

        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 9) < 2) op = illegal_ops[$urandom_range(0, 4)];
            else                          op = OPW'($urandom_range(1, 3));
            do_txn(op, rand_pl(), $urandom_range(0, 5), 1'($urandom_range(0, 1)), k1);
            if ($urandom_range(0, 1) == 1) begin
                search_end     = 1'b1;
                update_all_end = 1'b1;
                tick();
                search_end     = 1'b0;
                update_all_end = 1'b0;
            end
            repeat ($urandom_range(0, 2)) tick();
        end
        drain();
        check("issue_q_empty", DW'(issue_q.size()), DW'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cam_cmd_issuer.md
CAM_CMD_ISSUER -- requirements
Module: cam_cmd_issuer

Interface
REQ-001 Parameter C_DATA_WIDTH, 512, command word width; minimum 64.
REQ-002 Parameter OP_CODE_WIDTH, 3, opcode field width of request and response ports.
REQ-003 Parameter TIMEOUT_CYCLES, 1024, watchdog limit in cycles; minimum 2.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 cmd_valid  input  1  request present.
REQ-007 cmd_ready  output  1  issuer can accept a request.
REQ-008 cmd_op  input  OP_CODE_WIDTH  opcode: 1=UPDATE_ALL, 2=SEARCH, 3=UPDATE_ONE.
REQ-009 cmd_payload  input  C_DATA_WIDTH-32  operand bits.
REQ-010 data_out  output  C_DATA_WIDTH  command word to CAM: [31:0]=zero-extended opcode, [C_DATA_WIDTH-1:32]=payload.
REQ-011 data_out_valid  output  1  command word qualifier, one-cycle pulse.
REQ-012 search_end  input  1  CAM completion for SEARCH and UPDATE_ONE.
REQ-013 update_all_end  input  1  CAM completion for UPDATE_ALL.
REQ-014 resp_valid  output  1  completion record available.
REQ-015 resp_ready  input  1  consumer takes completion record.
REQ-016 resp_op  output  OP_CODE_WIDTH  opcode of completed request.
REQ-017 resp_err  output  1  request had illegal opcode, never issued.
REQ-018 resp_timeout  output  1  watchdog expired before completion.
REQ-019 cmd_count  output  16  count of words issued to CAM.

Function
REQ-020 State machine SHALL have states IDLE, ISSUE, WAIT_END, RESP; exactly one request in flight.
REQ-021 cmd_ready SHALL be 1 only in IDLE; handshake is cmd_valid && cmd_ready on a rising edge.
REQ-022 Legal opcode accepted: IDLE->ISSUE; opcode and payload registered.
REQ-023 Illegal opcode (0 or >3) accepted: IDLE->RESP with resp_err=1, no data_out_valid, cmd_count unchanged.
REQ-024 In ISSUE, data_out_valid SHALL be 1 for exactly one cycle (the cycle after acceptance), then ISSUE->WAIT_END.
REQ-025 data_out SHALL be all-zero whenever data_out_valid is 0.
REQ-026 cmd_count SHALL increment by 1 in each ISSUE cycle, wrapping 0xFFFF->0x0000.
REQ-027 search_end and update_all_end SHALL be ignored in IDLE, ISSUE and RESP.
REQ-028 In WAIT_END, UPDATE_ALL completes only on update_all_end; SEARCH/UPDATE_ONE only on search_end; the non-matching end signal is ignored.
REQ-029 On completion, WAIT_END->RESP the next edge with resp_err=0, resp_timeout=0.
REQ-030 In RESP, resp_valid=1 and resp_op/resp_err/resp_timeout SHALL hold stable until resp_ready; on resp_valid && resp_ready, RESP->IDLE.
REQ-031 Minimum request-to-next-acceptance: 4 cycles (accept, ISSUE, WAIT_END with end, RESP with resp_ready=1).
REQ-032 A request presented while busy SHALL not be accepted and SHALL not be lost.

Reset
REQ-033 rst_n low SHALL immediately force state IDLE, cmd_ready=0 during reset then 1, data_out=0, data_out_valid=0, resp_valid=0, resp_op=0, resp_err=0, resp_timeout=0, cmd_count=0, watchdog=0.
REQ-034 Reset mid-operation SHALL abandon the in-flight request without any response.

Configuration
REQ-035 Macro CAM_CMD_ISSUER_TIMEOUT_EN defined: watchdog counts WAIT_END cycles from 0; at count TIMEOUT_CYCLES-1 without completion, WAIT_END->RESP with resp_timeout=1; completion on that same cycle wins (resp_timeout=0).
REQ-036 Macro undefined: no watchdog logic, WAIT_END waits indefinitely, resp_timeout tied 0, TIMEOUT_CYCLES unused.

Verification
REQ-037 SEARCH op=2, payload=0xABCD -> one-cycle data_out_valid, data_out[31:0]=2, data_out[47:32]=0xABCD; search_end 5 cycles later -> resp_valid, resp_op=2, cmd_count=1.
REQ-038 UPDATE_ALL op=1 with search_end pulsed in WAIT_END -> no response; update_all_end -> resp_op=1.
REQ-039 op=5 -> resp_err=1 next cycle, no data_out_valid, cmd_count unchanged.
REQ-040 resp_ready held 0 for 10 cycles with cmd_valid=1 -> resp fields stable, cmd_ready=0, second request accepted only after resp_ready.
REQ-041 Macro defined, TIMEOUT_CYCLES=8, no end signal -> resp_timeout=1 after 8 WAIT_END cycles; macro undefined -> no response after 100 cycles.
REQ-042 rst_n low during WAIT_END -> outputs at reset values immediately, no response; cmd_count preloaded 0xFFFF plus one issue -> 0x0000.
